// File: rtl/seg_digit_scanner_if.sv
// Bus between a display producer and the digit scanner: value/load/blank_lz in,
// decoder code, anode enables and frame pulse out.
interface seg_digit_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    // load is a single-cycle strobe with no backpressure: the scanner accepts it on
    // every cycle it is high, so there is no ready signal.
    logic [4*NUM_DIGITS-1:0] value_in;
    logic                    load;
    logic                    blank_lz;
    logic [3:0]              digit_out;
    logic [NUM_DIGITS-1:0]   anode_n;
    logic                    frame_done;
    logic                    dbg_on;

    modport master (
        output value_in, load, blank_lz,
        input  digit_out, anode_n, frame_done, dbg_on
    );

    modport slave (
        input  value_in, load, blank_lz,
        output digit_out, anode_n, frame_done, dbg_on
    );
endinterface

// File: rtl/seg_digit_scanner.sv
// Time-multiplexes an N-digit BCD value onto one 7-segment decoder with a per-slot
// ghosting guard, optional leading-zero blanking and frame-synchronous value updates.
module seg_digit_scanner #(
    parameter int         NUM_DIGITS  = 4,
    parameter int         REFRESH_DIV = 50000,
    parameter int         GUARD       = 2,
    parameter logic [3:0] BLANK_CODE  = 4'hF
) (
    input  logic               clk,
    input  logic               reset_n,
    seg_digit_scanner_if.slave bus
);
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [VW-1:0]         display_q, display_d;
    logic [VW-1:0]         pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [3:0]            digit_q;
    logic [NUM_DIGITS-1:0] anode_q;
    logic                  frame_done_q;
    logic                  cnt_wrap;
    logic                  boundary;

    // Digit 0 is never blanked; a higher digit goes dark only when it and every
    // digit above it are zero.
    function automatic logic [3:0] digit_code(input logic [VW-1:0] disp,
                                              input logic [IW-1:0] idx,
                                              input logic          blz);
        logic upper_zero;
        upper_zero = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && disp[4*k +: 4] != 4'd0) upper_zero = 1'b0;
        end
        if (blz && idx != '0 && upper_zero) return BLANK_CODE;
        return disp[4*int'(idx) +: 4];
    endfunction

    always_comb begin
        cnt_wrap        = (cnt_q == CNT_LAST);
        boundary        = cnt_wrap && (idx_q == IDX_LAST);
        cnt_d           = cnt_wrap ? '0 : cnt_q + 1'b1;
        idx_d           = idx_q;
        display_d       = display_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        if (cnt_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        // A load landing on the boundary itself beats any older pending value.
        if (boundary) begin
            pending_valid_d = 1'b0;
            if (bus.load)            display_d = bus.value_in;
            else if (pending_valid_q) display_d = pending_q;
        end else if (bus.load) begin
            pending_d       = bus.value_in;
            pending_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_GUARD;
            cnt_q           <= '0;
            idx_q           <= '0;
            display_q       <= {NUM_DIGITS{BLANK_CODE}};
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            digit_q         <= BLANK_CODE;
            anode_q         <= '1;
            frame_done_q    <= 1'b0;
        end else begin
            cnt_q           <= cnt_d;
            idx_q           <= idx_d;
            display_q       <= display_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            frame_done_q    <= (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
            // The code is latched once per slot so it stays stable through guard and ON.
            if (cnt_wrap) digit_q <= digit_code(display_d, idx_d, bus.blank_lz);
            case (state_q)
                ST_GUARD: begin
                    if (cnt_d >= CNT_GUARD) begin
                        state_q <= ST_ON;
                        anode_q <= ~(NUM_DIGITS'(1) << idx_d);
                    end
                end
                ST_ON: begin
                    if (cnt_wrap) begin
                        state_q <= ST_GUARD;
                        anode_q <= '1;
                    end
                end
                default: begin
                    state_q <= ST_GUARD;
                    anode_q <= '1;
                end
            endcase
        end
    end

    assign bus.digit_out  = digit_q;
    assign bus.anode_n    = anode_q;
    assign bus.frame_done = frame_done_q;
    assign bus.dbg_on     = (state_q == ST_ON);
endmodule

// File: tb/tb_seg_digit_scanner.sv
// Bench for seg_digit_scanner: directed scenarios plus random loads/blanking,
// all checked every cycle against a slot/frame-level reference model.
module tb_seg_digit_scanner;
    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int GRD   = 2;
    localparam int FRAME = ND * DIV;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    seg_digit_scanner_if #(.NUM_DIGITS(ND)) bus ();

    seg_digit_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(DIV),
        .GUARD      (GRD),
        .BLANK_CODE (4'hF)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference model: t counts cycles since reset release, so slot and frame
    // position follow from plain division.
    int          t;
    logic [15:0] m_disp;
    logic [15:0] m_pend;
    bit          m_pv;
    logic [3:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, expv, t);
        end
    endtask

    function automatic logic [3:0] ref_code(input logic [15:0] disp, input int idx, input bit blz);
        logic [15:0] upper;
        upper = disp >> (4 * idx);
        if (blz && idx != 0 && upper == 16'd0) return 4'hF;
        return upper[3:0];
    endfunction

    task automatic model_reset();
        t      = 0;
        m_disp = 16'hFFFF;
        m_pend = 16'h0000;
        m_pv   = 1'b0;
        exp_q.delete();
        exp_q.push_back(4'hF);
    endtask

    task automatic model_edge();
        int cnt;
        int idx;
        cnt = t % DIV;
        idx = (t / DIV) % ND;
        if (cnt == DIV - 1 && idx == ND - 1) begin
            if (bus.load)  m_disp = bus.value_in;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
        end else if (bus.load) begin
            m_pend = bus.value_in;
            m_pv   = 1'b1;
        end
        t++;
        if (t % DIV == 0) begin
            exp_q.push_back(ref_code(m_disp, (t / DIV) % ND, bus.blank_lz));
            if (exp_q.size() > 16) void'(exp_q.pop_front());
        end
    endtask

    task automatic check_outputs();
        int         cnt;
        int         idx;
        logic [3:0] ea;
        cnt = t % DIV;
        idx = (t / DIV) % ND;
        ea  = (cnt < GRD) ? 4'hF : (4'hF ^ (4'h1 << idx));
        check("anode_n", bus.anode_n, ea);
        check("digit_out", bus.digit_out, exp_q[$]);
        check("frame_done", bus.frame_done, (t % FRAME) == FRAME - 1);
        check("dbg_on", bus.dbg_on, cnt >= GRD);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_anode_n"}, bus.anode_n, 4'hF);
        check({tag, "_digit_out"}, bus.digit_out, 4'hF);
        check({tag, "_frame_done"}, bus.frame_done, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < FRAME && (t % FRAME) != target; i++) tick();
        check("run_to_phase", t % FRAME, target);
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.value_in = v;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    // Checks one whole frame against constant digit codes, sampling mid-ON of each slot.
    task automatic expect_frame(input logic [3:0] d0, input logic [3:0] d1,
                                input logic [3:0] d2, input logic [3:0] d3);
        logic [3:0] d[ND];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        check("frame_start", t % FRAME, 0);
        for (int s = 0; s < ND; s++) begin
            for (int c = 0; c < DIV; c++) begin
                if (c == 4) begin
                    check("frame_digit", bus.digit_out, d[s]);
                    check("frame_anode", bus.anode_n, 4'hF ^ (4'h1 << s));
                end
                tick();
            end
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        bus.value_in = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        model_reset();

        // 1: reset values, guard timing and frame pulse period
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        reset_n = 1'b1;
        #1 check_outputs();
        check("t1_cyc0_anode", bus.anode_n, 4'hF);
        tick();
        check("t1_cyc1_anode", bus.anode_n, 4'hF);
        tick();
        check("t1_cyc2_anode", bus.anode_n, 4'hE);
        run_to(FRAME - 1);
        check("t1_frame_done_hi", bus.frame_done, 1'b1);
        tick();
        check("t1_frame_done_lo", bus.frame_done, 1'b0);

        // 2: mid-frame load appears only from the next frame
        run_to(10);
        do_load(16'h1234);
        check("t2_cur_frame", bus.digit_out, 4'hF);
        run_to(0);
        expect_frame(4'h4, 4'h3, 4'h2, 4'h1);

        // 3: leading-zero blanking
        bus.blank_lz = 1'b1;
        run_to(10);
        do_load(16'h0070);
        run_to(0);
        expect_frame(4'h0, 4'h7, 4'hF, 4'hF);
        run_to(10);
        do_load(16'h0000);
        run_to(0);
        expect_frame(4'h0, 4'hF, 4'hF, 4'hF);
        bus.blank_lz = 1'b0;
        run_to(10);
        do_load(16'h0070);
        run_to(0);
        expect_frame(4'h0, 4'h7, 4'h0, 4'h0);

        // 4: last load in a frame wins
        run_to(5);
        do_load(16'h1111);
        run_to(20);
        do_load(16'h2222);
        run_to(0);
        expect_frame(4'h2, 4'h2, 4'h2, 4'h2);

        // 5: load on the boundary cycle beats an older pending value
        run_to(10);
        do_load(16'h9999);
        run_to(FRAME - 1);
        check("t5_boundary_pulse", bus.frame_done, 1'b1);
        do_load(16'h5678);
        expect_frame(4'h8, 4'h7, 4'h6, 4'h5);
        expect_frame(4'h8, 4'h7, 4'h6, 4'h5);

        // 6: asynchronous reset mid-slot discards a pending load
        run_to(3);
        do_load(16'h4321);
        run_to(21);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("held_reset");
        reset_n = 1'b1;
        #1 check_outputs();
        expect_frame(4'hF, 4'hF, 4'hF, 4'hF);
        expect_frame(4'hF, 4'hF, 4'hF, 4'hF);

        // Random loads, values (non-BCD codes and zero runs included) and blanking
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) bus.blank_lz = ~bus.blank_lz;
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < ND; k++)
                    bus.value_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                bus.load = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            tick();
        end
        bus.load = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
